// File: rtl/block_scan_vga.sv
// Raster scanner for a 32x32 block grid: outputs the block address combinationally and registers rgb/hs/vs one pixel behind.
// The scan runs freely with no backpressure; pixels advance one step on every fourth clock.
module block_scan_vga #(
    parameter int H_VIS   = 640,
    parameter int H_FP    = 16,
    parameter int H_SYNC  = 96,
    parameter int H_BP    = 48,
    parameter int V_VIS   = 480,
    parameter int V_FP    = 10,
    parameter int V_SYNC  = 2,
    parameter int V_BP    = 33,
    parameter int GRID_X0 = 80,
    parameter int BLK_PX  = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  BlockState,
    output logic [4:0]  xBlockNum,
    output logic [4:0]  yBlockNum,
    output logic [11:0] rgb,
    output logic        hs,
    output logic        vs,
    output logic        frame_tick
);
    localparam int H_TOT  = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT  = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int GRID_W = 32 * BLK_PX;

    localparam logic [9:0] H_LAST   = 10'(H_TOT - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOT - 1);
    localparam logic [9:0] H_VIS_C  = 10'(H_VIS);
    localparam logic [9:0] V_VIS_C  = 10'(V_VIS);
    localparam logic [9:0] HS_ON    = 10'(H_VIS + H_FP);
    localparam logic [9:0] HS_OFF   = 10'(H_VIS + H_FP + H_SYNC);
    localparam logic [9:0] VS_ON    = 10'(V_VIS + V_FP);
    localparam logic [9:0] VS_OFF   = 10'(V_VIS + V_FP + V_SYNC);
    localparam logic [9:0] GX_LO    = 10'(GRID_X0);
    localparam logic [9:0] GX_HI    = 10'(GRID_X0 + GRID_W);
    localparam logic [9:0] GY_HI    = 10'(GRID_W);
    localparam logic [3:0] SUB_LAST = 4'(BLK_PX - 1);

    logic [1:0]  div;
    logic        pix_en;
    logic [9:0]  hcnt, vcnt, h_nxt;
    logic [3:0]  x_sub, y_sub;
    logic [4:0]  x_blk, y_blk;
    logic        line_end, frame_end;
    logic        h_in, v_in, in_grid;
    logic [11:0] blk_colour, pix_colour;

    assign pix_en    = (div == 2'd3);
    assign line_end  = (hcnt == H_LAST);
    assign frame_end = line_end && (vcnt == V_LAST);
    assign h_nxt     = line_end ? 10'd0 : hcnt + 10'd1;
    assign h_in      = (hcnt >= GX_LO) && (hcnt < GX_HI);
    assign v_in      = (vcnt < GY_HI);
    assign in_grid   = h_in && v_in;

    assign xBlockNum  = in_grid ? x_blk : 5'd0;
    assign yBlockNum  = in_grid ? y_blk : 5'd0;
    assign frame_tick = pix_en && frame_end;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) div <= 2'd0;
        else      div <= div + 2'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hcnt <= 10'd0;
            vcnt <= 10'd0;
        end else if (pix_en) begin
            hcnt <= h_nxt;
            if (line_end) vcnt <= frame_end ? 10'd0 : vcnt + 10'd1;
        end
    end

    // Block counters track the current pixel; they rest at zero outside the grid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_sub <= 4'd0;
            x_blk <= 5'd0;
        end else if (pix_en) begin
            if (h_in && (h_nxt != GX_LO)) begin
                if (x_sub == SUB_LAST) begin
                    x_sub <= 4'd0;
                    x_blk <= x_blk + 5'd1;
                end else begin
                    x_sub <= x_sub + 4'd1;
                end
            end else begin
                x_sub <= 4'd0;
                x_blk <= 5'd0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            y_sub <= 4'd0;
            y_blk <= 5'd0;
        end else if (pix_en && line_end) begin
            if (v_in && !frame_end) begin
                if (y_sub == SUB_LAST) begin
                    y_sub <= 4'd0;
                    y_blk <= y_blk + 5'd1;
                end else begin
                    y_sub <= y_sub + 4'd1;
                end
            end else begin
                y_sub <= 4'd0;
                y_blk <= 5'd0;
            end
        end
    end

    always_comb begin
        blk_colour = 12'hFFF;
        case (BlockState)
            4'd0:    blk_colour = 12'h000;
            4'd1:    blk_colour = 12'h0F0;
            4'd2:    blk_colour = 12'hFF0;
            4'd3:    blk_colour = 12'hF00;
            4'd4:    blk_colour = 12'h888;
            default: blk_colour = 12'hFFF;
        endcase
        pix_colour = 12'h000;
        if (in_grid)                                  pix_colour = blk_colour;
        else if ((hcnt < H_VIS_C) && (vcnt < V_VIS_C)) pix_colour = 12'h003;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rgb <= 12'h000;
            hs  <= 1'b1;
            vs  <= 1'b1;
        end else if (pix_en) begin
            rgb <= pix_colour;
            hs  <= !((hcnt >= HS_ON) && (hcnt < HS_OFF));
            vs  <= !((vcnt >= VS_ON) && (vcnt < VS_OFF));
        end
    end
endmodule

// File: doc/block_scan_vga.md
BLOCK_SCAN_VGA -- requirements
Module: block_scan_vga

Parameters
REQ-001 H_VIS, 640, visible pixels per line.
REQ-002 H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porches and sync width in pixels (line total 800).
REQ-003 V_VIS, 480, visible lines per frame.
REQ-004 V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porches and sync width in lines (frame total 525).
REQ-005 GRID_X0, 80, first pixel column of the 32x32 block grid.
REQ-006 BLK_PX, 15, block edge in pixels; grid spans 480x480, columns 80..559, lines 0..479.

Interface
REQ-007 clk  in  1  system clock, 100 MHz.
REQ-008 rst  in  1  reset; one clock; reset is asynchronous and active-low.
REQ-009 BlockState  in  4  state of the addressed block, combinational from the block-state register file.
REQ-010 xBlockNum  out  5  column of the block under the current pixel, driven to the register file.
REQ-011 yBlockNum  out  5  row of the block under the current pixel, driven to the register file.
REQ-012 rgb  out  12  pixel colour, {R[3:0],G[3:0],B[3:0]}, registered.
REQ-013 hs  out  1  horizontal sync, active-low, registered.
REQ-014 vs  out  1  vertical sync, active-low, registered.
REQ-015 frame_tick  out  1  one-clk pulse at end of each frame, for game-logic pacing.

Function
REQ-016 A 2-bit divider SHALL produce pix_en high one clk in every 4 (25 MHz pixel rate); all counters and registered outputs update only on pix_en, except frame_tick.
REQ-017 hcnt SHALL count 0..799 and wrap to 0; vcnt SHALL increment when hcnt wraps, count 0..524 and wrap to 0.
REQ-018 xBlockNum/yBlockNum SHALL be derived with sub-block counters (0..14) and block counters, no dividers: xBlockNum = (hcnt-80)/15, yBlockNum = vcnt/15, for the current hcnt/vcnt.
REQ-019 Outside the grid (hcnt<80, hcnt>=560, or vcnt>=480), xBlockNum and yBlockNum SHALL be 0.
REQ-020 On pix_en, rgb SHALL be loaded from the current pixel: in grid -> colour map of BlockState; visible but outside grid -> 12'h003; blanking (hcnt>=640 or vcnt>=480) -> 12'h000.
REQ-021 Colour map: 0 -> 12'h000, 1 -> 12'h0F0 body, 2 -> 12'hFF0 head, 3 -> 12'hF00 food, 4 -> 12'h888 wall, 5..15 -> 12'hFFF.
REQ-022 On pix_en, hs SHALL load 0 iff hcnt in [656,752), else 1; vs SHALL load 0 iff vcnt in [490,492), else 1.
REQ-023 rgb, hs and vs SHALL all lag the counters by exactly one pixel, keeping colour and sync aligned.
REQ-024 frame_tick SHALL be 1 for exactly the single clk in which pix_en=1, hcnt=799 and vcnt=524; otherwise 0.
REQ-025 BlockState SHALL be sampled only on pix_en; changes between pix_en edges SHALL have no effect.

Reset
REQ-026 While rst=0: divider, hcnt, vcnt, sub-block and block counters = 0; xBlockNum=yBlockNum=0; rgb=12'h000; hs=1; vs=1; frame_tick=0; applied immediately, without waiting for clk.
REQ-027 Reset asserted mid-line or mid-frame SHALL abort the scan; after release scanning restarts at hcnt=0, vcnt=0, with the first pix_en on the 4th rising clk.

Verification
REQ-028 Release reset, run 2 lines -> hs falls 657 pixels after first pix_en, stays low 384 clk; line period 3200 clk.
REQ-029 Run 2 frames -> vs low 6400 clk per frame; frame_tick exactly once per 1,680,000 clk, coincident with hcnt=799/vcnt=524.
REQ-030 Probe hcnt=125, vcnt=37 -> xBlockNum=3, yBlockNum=2; hcnt=559 -> xBlockNum=31; hcnt=560 -> xBlockNum=0, next rgb=12'h003; hcnt=79 -> rgb 12'h003.
REQ-031 Hold BlockState=2 -> all in-grid pixels 12'hFF0; BlockState=9 -> 12'hFFF; hcnt 640..799 -> rgb 12'h000 regardless of BlockState.
REQ-032 Assert rst at hcnt=300, vcnt=100 between clk edges -> rgb=0, hs=vs=1 immediately; after release first hs low after 657 pixels.
